// File: rtl/coin_credit_controller_pkg.sv
// -----------------------------------------------------------------------------
// coin_pkg
// Shared definitions for the coin credit / vending controller:
//   MAX_DRINKS      - size of the price table (number of physical button slots)
//   COIN100_VAL     - credit value of a 100 coin, in units of 100
//   COIN500_VAL     - credit value of a 500 coin, in units of 100
//   price_t         - one price table entry, in units of 100
//   DEFAULT_PRICES  - factory price table, index 0 is drink button 0
//   state_t         - controller state
// -----------------------------------------------------------------------------
package coin_pkg;

    localparam int MAX_DRINKS  = 8;
    localparam int COIN100_VAL = 1;
    localparam int COIN500_VAL = 5;

    typedef logic [7:0] price_t;

    // Unpacked so that element 0 is the leftmost literal (drink 0 costs 3).
    localparam price_t DEFAULT_PRICES [MAX_DRINKS] = '{
        8'd3, 8'd5, 8'd6, 8'd8, 8'd4, 8'd7, 8'd9, 8'd10
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREW   = 2'd1,
        CHANGE = 2'd2
    } state_t;

endpackage

// File: rtl/coin_credit_controller_edge_detect.sv
// -----------------------------------------------------------------------------
// coin_edge_detect
// Rising-edge detector for one coin acceptor level.
//   clk    in  : system clock, rising edge
//   rst    in  : asynchronous active-low reset
//   level  in  : coin acceptor level (synchronous to clk)
//   pulse  out : high for the single cycle in which level rises
//
// The previous-level register resets to 1, so a level that is already high
// when reset is released is treated as "seen" and does not produce a pulse.
// -----------------------------------------------------------------------------
module coin_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/coin_credit_controller.sv
// -----------------------------------------------------------------------------
// coin_credit_controller
// Credit and vending controller for the coffee machine. Accumulates 100/500
// coins into a saturating credit, validates a drink selection against the
// price table, runs the brewer handshake and presents change.
//
// Parameters:
//   N_DRINKS   - number of drink buttons (1..MAX_DRINKS)
//   CREDIT_W   - width of all money values (units of 100)
//   MAX_CREDIT - credit ceiling, must be < 2**CREDIT_W
//   PRICES     - price table, entries 0..N_DRINKS-1 used
//
// Ports:
//   clk          in  : clock, rising edge
//   rst          in  : asynchronous active-low reset
//   m100, m500   in  : coin levels, each rising edge is one coin
//   drink_sel    in  : drink buttons (level), lowest set index wins
//   cancel       in  : refund request (only when COIN_CANCEL_EN is defined)
//   readyIn      in  : brewer done, looked at only while brewing
//   change_ack   in  : change collected
//   enable       out : brew request, high throughout BREW
//   precioBebida out : price of the accepted drink during BREW/CHANGE
//   vuelto       out : change amount while change_valid, else 0
//   change_valid out : change presented
//   credit       out : current credit
//   drink_id     out : accepted drink index, held BREW..CHANGE
//   coin_reject  out : one-cycle pulse, a coin was returned
//   insufficient out : one-cycle pulse, selection refused for lack of credit
//
// Configuration macro:
//   COIN_CANCEL_EN - adds the cancel port; in IDLE with nonzero credit a
//                    cancel refunds the whole credit through CHANGE.
// -----------------------------------------------------------------------------
module coin_credit_controller
    import coin_pkg::*;
#(
    parameter int     N_DRINKS   = 4,
    parameter int     CREDIT_W   = 8,
    parameter int     MAX_CREDIT = 99,
    parameter price_t PRICES [MAX_DRINKS] = coin_pkg::DEFAULT_PRICES,
    localparam int    DID_W      = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m100,
    input  logic                m500,
    input  logic [N_DRINKS-1:0] drink_sel,
`ifdef COIN_CANCEL_EN
    input  logic                cancel,
`endif
    input  logic                readyIn,
    input  logic                change_ack,
    output logic                enable,
    output logic [CREDIT_W-1:0] precioBebida,
    output logic [CREDIT_W-1:0] vuelto,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic [DID_W-1:0]    drink_id,
    output logic                coin_reject,
    output logic                insufficient
);

    localparam logic [CREDIT_W:0] SUM_LIMIT = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0] VAL100    = (CREDIT_W+1)'(COIN100_VAL);
    localparam logic [CREDIT_W:0] VAL500    = (CREDIT_W+1)'(COIN500_VAL);

    state_t state;

    logic                e100;
    logic                e500;
    logic                coin_any;
    logic [CREDIT_W:0]   coin_add;
    logic [CREDIT_W:0]   coin_sum;
    logic                sum_ok;
    logic [CREDIT_W-1:0] credit_eff;

    logic                sel_hit;
    logic [DID_W-1:0]    sel_idx;
    logic [CREDIT_W-1:0] sel_price;
    logic                cancel_req;

    coin_edge_detect u_edge100 (
        .clk   (clk),
        .rst   (rst),
        .level (m100),
        .pulse (e100)
    );

    coin_edge_detect u_edge500 (
        .clk   (clk),
        .rst   (rst),
        .level (m500),
        .pulse (e500)
    );

    // Coin arithmetic is one bit wider than credit so the ceiling compare
    // cannot be fooled by wrap-around. Simultaneous coins are one deposit.
    assign coin_any = e100 | e500;
    assign coin_add = (e100 ? VAL100 : '0) + (e500 ? VAL500 : '0);
    assign coin_sum = {1'b0, credit} + coin_add;
    assign sum_ok   = (coin_sum <= SUM_LIMIT);

    // Credit as seen by a selection or cancel in the same cycle as a coin:
    // an accepted coin is counted first.
    assign credit_eff = (state == IDLE && coin_any && sum_ok) ?
                        coin_sum[CREDIT_W-1:0] : credit;

    // Lowest set button wins: scanning downward lets the lowest index
    // overwrite any higher one.
    always_comb begin
        sel_hit   = 1'b0;
        sel_idx   = '0;
        sel_price = '0;
        for (int i = N_DRINKS - 1; i >= 0; i--) begin
            if (drink_sel[i]) begin
                sel_hit   = 1'b1;
                sel_idx   = DID_W'(i);
                sel_price = CREDIT_W'(PRICES[i]);
            end
        end
    end

`ifdef COIN_CANCEL_EN
    assign cancel_req = cancel && (credit_eff != '0);
`else
    assign cancel_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            enable       <= 1'b0;
            precioBebida <= '0;
            vuelto       <= '0;
            change_valid <= 1'b0;
            credit       <= '0;
            drink_id     <= '0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;

            case (state)
                IDLE: begin
                    coin_reject <= coin_any && !sum_ok;
                    if (cancel_req) begin
                        // Refund: whole credit goes out as change, no brew.
                        state        <= CHANGE;
                        vuelto       <= credit_eff;
                        change_valid <= 1'b1;
                        credit       <= '0;
                    end else if (sel_hit && (credit_eff >= sel_price)) begin
                        state        <= BREW;
                        enable       <= 1'b1;
                        precioBebida <= sel_price;
                        drink_id     <= sel_idx;
                        credit       <= credit_eff - sel_price;
                    end else begin
                        insufficient <= sel_hit;
                        credit       <= credit_eff;
                    end
                end

                BREW: begin
                    coin_reject <= coin_any;
                    if (readyIn) begin
                        enable <= 1'b0;
                        if (credit != '0) begin
                            state        <= CHANGE;
                            vuelto       <= credit;
                            change_valid <= 1'b1;
                            credit       <= '0;
                        end else begin
                            // Exact payment: nothing to hand back.
                            state        <= IDLE;
                            precioBebida <= '0;
                            drink_id     <= '0;
                        end
                    end
                end

                CHANGE: begin
                    coin_reject <= coin_any;
                    if (change_ack) begin
                        state        <= IDLE;
                        change_valid <= 1'b0;
                        vuelto       <= '0;
                        precioBebida <= '0;
                        drink_id     <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_credit_controller.sv
module tb_coin_credit_controller;

    localparam int N_DRINKS   = 4;
    localparam int CREDIT_W   = 8;
    localparam int MAX_CREDIT = 99;

    logic                clk = 1'b0;
    logic                rst;
    logic                m100;
    logic                m500;
    logic [N_DRINKS-1:0] drink_sel;
`ifdef COIN_CANCEL_EN
    logic                cancel;
`endif
    logic                readyIn;
    logic                change_ack;
    logic                enable;
    logic [CREDIT_W-1:0] precioBebida;
    logic [CREDIT_W-1:0] vuelto;
    logic                change_valid;
    logic [CREDIT_W-1:0] credit;
    logic [1:0]          drink_id;
    logic                coin_reject;
    logic                insufficient;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: credit in units, and the price list.
    int m_credit;
    int price_tab [8] = '{3, 5, 6, 8, 4, 7, 9, 10};

    coin_credit_controller #(
        .N_DRINKS   (N_DRINKS),
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m100         (m100),
        .m500         (m500),
        .drink_sel    (drink_sel),
`ifdef COIN_CANCEL_EN
        .cancel       (cancel),
`endif
        .readyIn      (readyIn),
        .change_ack   (change_ack),
        .enable       (enable),
        .precioBebida (precioBebida),
        .vuelto       (vuelto),
        .change_valid (change_valid),
        .credit       (credit),
        .drink_id     (drink_id),
        .coin_reject  (coin_reject),
        .insufficient (insufficient)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One coin deposit: level high for two cycles, then low for one.
    task automatic coin(input bit c100, input bit c500, output logic rej);
        m100 = c100;
        m500 = c500;
        tick();
        rej = coin_reject;
        tick();
        m100 = 1'b0;
        m500 = 1'b0;
        tick();
    endtask

    // Buy a drink, finish the brew and collect any change.
    task automatic buy(input logic [N_DRINKS-1:0] mask, output logic [CREDIT_W-1:0] v);
        drink_sel = mask;
        tick();
        drink_sel = '0;
        readyIn = 1'b1;
        tick();
        readyIn = 1'b0;
        v = vuelto;
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        m_credit = 0;
    endtask

    task automatic test_reset();
        logic rej;
        rst = 1'b0; m100 = 1'b1; m500 = 1'b0; drink_sel = '0;
        readyIn = 1'b0; change_ack = 1'b0;
`ifdef COIN_CANCEL_EN
        cancel = 1'b0;
`endif
        #3;
        n_checks++; if ({enable, precioBebida, vuelto, change_valid, credit, drink_id, coin_reject, insufficient} !== '0) begin n_fail++; $display("FAIL reset_outputs: got en=%0b p=%0d v=%0d cv=%0b c=%0d id=%0d", enable, precioBebida, vuelto, change_valid, credit, drink_id); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (credit !== 8'd0) begin n_fail++; $display("FAIL coin_held_across_reset: credit %0d expected 0", credit); end
        m100 = 1'b0;
        tick();
        coin(1'b1, 1'b0, rej);
        n_checks++; if (credit !== 8'd1) begin n_fail++; $display("FAIL first_coin_after_reset: credit %0d expected 1", credit); end
        do_reset();
    endtask

    task automatic test_basic_purchase();
        logic rej;
        coin(1'b1, 1'b0, rej);
        coin(1'b1, 1'b0, rej);
        n_checks++; if (credit !== 8'd2) begin n_fail++; $display("FAIL basic_two_100: credit %0d expected 2", credit); end
        coin(1'b0, 1'b1, rej);
        n_checks++; if (credit !== 8'd7) begin n_fail++; $display("FAIL basic_credit7: credit %0d expected 7", credit); end
        drink_sel = 4'b0100;
        tick();
        drink_sel = '0;
        n_checks++; if ({enable, precioBebida, credit, drink_id} !== {1'b1, 8'd6, 8'd1, 2'd2}) begin n_fail++; $display("FAIL basic_accept: en=%0b p=%0d c=%0d id=%0d expected 1/6/1/2", enable, precioBebida, credit, drink_id); end
        tick();
        tick();
        n_checks++; if (enable !== 1'b1) begin n_fail++; $display("FAIL basic_enable_hold: enable %0b expected 1", enable); end
        readyIn = 1'b1;
        tick();
        readyIn = 1'b0;
        n_checks++; if ({enable, change_valid, vuelto, credit, precioBebida} !== {1'b0, 1'b1, 8'd1, 8'd0, 8'd6}) begin n_fail++; $display("FAIL basic_change: en=%0b cv=%0b v=%0d c=%0d p=%0d expected 0/1/1/0/6", enable, change_valid, vuelto, credit, precioBebida); end
        tick();
        n_checks++; if ({change_valid, vuelto} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL basic_change_hold: cv=%0b v=%0d expected 1/1", change_valid, vuelto); end
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        n_checks++; if ({enable, precioBebida, vuelto, change_valid, credit, drink_id} !== '0) begin n_fail++; $display("FAIL basic_back_idle: en=%0b p=%0d v=%0d cv=%0b c=%0d id=%0d expected all 0", enable, precioBebida, vuelto, change_valid, credit, drink_id); end
    endtask

    task automatic test_change_five();
        logic rej;
        logic [CREDIT_W-1:0] v;
        coin(1'b0, 1'b1, rej);
        coin(1'b0, 1'b1, rej);
        n_checks++; if (credit !== 8'd10) begin n_fail++; $display("FAIL five_credit10: credit %0d expected 10", credit); end
        drink_sel = 4'b0010;
        tick();
        n_checks++; if ({precioBebida, drink_id, credit} !== {8'd5, 2'd1, 8'd5}) begin n_fail++; $display("FAIL five_accept: p=%0d id=%0d c=%0d expected 5/1/5", precioBebida, drink_id, credit); end
        drink_sel = '0;
        readyIn = 1'b1;
        tick();
        readyIn = 1'b0;
        v = vuelto;
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        n_checks++; if (v !== 8'd5) begin n_fail++; $display("FAIL five_vuelto: vuelto %0d expected 5", v); end
    endtask

    task automatic test_insufficient();
        logic rej;
        logic [CREDIT_W-1:0] v;
        coin(1'b1, 1'b0, rej);
        coin(1'b1, 1'b0, rej);
        drink_sel = 4'b1000;
        tick();
        n_checks++; if ({insufficient, credit, enable} !== {1'b1, 8'd2, 1'b0}) begin n_fail++; $display("FAIL insuf_first: ins=%0b c=%0d en=%0b expected 1/2/0", insufficient, credit, enable); end
        tick();
        n_checks++; if (insufficient !== 1'b1) begin n_fail++; $display("FAIL insuf_held: ins=%0b expected 1", insufficient); end
        drink_sel = '0;
        tick();
        n_checks++; if (insufficient !== 1'b0) begin n_fail++; $display("FAIL insuf_release: ins=%0b expected 0", insufficient); end
        coin(1'b0, 1'b1, rej);
        n_checks++; if (credit !== 8'd7) begin n_fail++; $display("FAIL insuf_credit7: credit %0d expected 7", credit); end
        drink_sel = 4'b1000;
        tick();
        drink_sel = '0;
        n_checks++; if ({insufficient, credit, enable} !== {1'b1, 8'd7, 1'b0}) begin n_fail++; $display("FAIL insuf_still: ins=%0b c=%0d en=%0b expected 1/7/0", insufficient, credit, enable); end
        tick();
        buy(4'b0100, v);
        n_checks++; if ({v, credit} !== {8'd1, 8'd0}) begin n_fail++; $display("FAIL insuf_drain: v=%0d c=%0d expected 1/0", v, credit); end
    endtask

    task automatic test_saturation();
        logic rej;
        logic [CREDIT_W-1:0] v;
        for (int i = 0; i < 19; i++) coin(1'b0, 1'b1, rej);
        coin(1'b1, 1'b0, rej);
        coin(1'b1, 1'b0, rej);
        n_checks++; if (credit !== 8'd97) begin n_fail++; $display("FAIL sat_credit97: credit %0d expected 97", credit); end
        coin(1'b0, 1'b1, rej);
        n_checks++; if ({rej, credit} !== {1'b1, 8'd97}) begin n_fail++; $display("FAIL sat_reject500: rej=%0b c=%0d expected 1/97", rej, credit); end
        coin(1'b1, 1'b0, rej);
        coin(1'b1, 1'b0, rej);
        n_checks++; if ({rej, credit} !== {1'b0, 8'd99}) begin n_fail++; $display("FAIL sat_credit99: rej=%0b c=%0d expected 0/99", rej, credit); end
        coin(1'b1, 1'b0, rej);
        n_checks++; if ({rej, credit} !== {1'b1, 8'd99}) begin n_fail++; $display("FAIL sat_reject100: rej=%0b c=%0d expected 1/99", rej, credit); end
        n_checks++; if (coin_reject !== 1'b0) begin n_fail++; $display("FAIL sat_reject_pulse: coin_reject %0b expected 0 after pulse", coin_reject); end
        buy(4'b1000, v);
        n_checks++; if (v !== 8'd91) begin n_fail++; $display("FAIL sat_drain: vuelto %0d expected 91", v); end
        coin(1'b1, 1'b1, rej);
        n_checks++; if ({rej, credit} !== {1'b0, 8'd6}) begin n_fail++; $display("FAIL sat_simultaneous: rej=%0b c=%0d expected 0/6", rej, credit); end
        buy(4'b0001, v);
        n_checks++; if (v !== 8'd3) begin n_fail++; $display("FAIL sat_drain2: vuelto %0d expected 3", v); end
    endtask

    task automatic test_priority_zero_change();
        logic rej;
        coin(1'b0, 1'b1, rej);
        drink_sel = 4'b1010;
        tick();
        drink_sel = '0;
        n_checks++; if ({enable, drink_id, precioBebida, credit} !== {1'b1, 2'd1, 8'd5, 8'd0}) begin n_fail++; $display("FAIL prio_accept: en=%0b id=%0d p=%0d c=%0d expected 1/1/5/0", enable, drink_id, precioBebida, credit); end
        m100 = 1'b1;
        tick();
        n_checks++; if ({coin_reject, credit} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL brew_coin_reject: rej=%0b c=%0d expected 1/0", coin_reject, credit); end
        m100 = 1'b0;
        tick();
        readyIn = 1'b1;
        tick();
        readyIn = 1'b0;
        n_checks++; if ({enable, change_valid, precioBebida, drink_id} !== '0) begin n_fail++; $display("FAIL prio_no_change: en=%0b cv=%0b p=%0d id=%0d expected all 0", enable, change_valid, precioBebida, drink_id); end
        coin(1'b1, 1'b0, rej);
        n_checks++; if ({rej, credit} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL prio_idle_again: rej=%0b c=%0d expected 0/1", rej, credit); end
        do_reset();
    endtask

    task automatic test_back_to_back_ack();
        logic rej;
        coin(1'b0, 1'b1, rej);
        coin(1'b1, 1'b0, rej);
        drink_sel = 4'b0001;
        tick();
        drink_sel = '0;
        readyIn = 1'b1;
        change_ack = 1'b1;
        tick();
        readyIn = 1'b0;
        n_checks++; if ({change_valid, vuelto} !== {1'b1, 8'd3}) begin n_fail++; $display("FAIL early_ack_enter: cv=%0b v=%0d expected 1/3", change_valid, vuelto); end
        tick();
        change_ack = 1'b0;
        n_checks++; if ({change_valid, vuelto} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL early_ack_one_cycle: cv=%0b v=%0d expected 0/0", change_valid, vuelto); end
    endtask

    task automatic test_reset_mid_brew();
        logic rej;
        coin(1'b0, 1'b1, rej);
        coin(1'b1, 1'b0, rej);
        drink_sel = 4'b0010;
        tick();
        drink_sel = '0;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if ({enable, credit, change_valid, precioBebida} !== '0) begin n_fail++; $display("FAIL reset_mid_brew: en=%0b c=%0d cv=%0b p=%0d expected all 0", enable, credit, change_valid, precioBebida); end
        tick();
        rst = 1'b1;
        tick();
        readyIn = 1'b1;
        tick();
        readyIn = 1'b0;
        n_checks++; if ({change_valid, vuelto} !== '0) begin n_fail++; $display("FAIL reset_no_change: cv=%0b v=%0d expected 0/0", change_valid, vuelto); end
        m_credit = 0;
    endtask

`ifdef COIN_CANCEL_EN
    task automatic test_cancel();
        logic rej;
        cancel = 1'b1;
        tick();
        n_checks++; if (change_valid !== 1'b0) begin n_fail++; $display("FAIL cancel_zero_credit: cv=%0b expected 0", change_valid); end
        cancel = 1'b0;
        coin(1'b0, 1'b1, rej);
        coin(1'b1, 1'b0, rej);
        cancel = 1'b1;
        drink_sel = 4'b0001;
        tick();
        cancel = 1'b0;
        drink_sel = '0;
        n_checks++; if ({change_valid, vuelto, credit, enable} !== {1'b1, 8'd6, 8'd0, 1'b0}) begin n_fail++; $display("FAIL cancel_refund: cv=%0b v=%0d c=%0d en=%0b expected 1/6/0/0", change_valid, vuelto, credit, enable); end
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
    endtask
`endif

    // Randomized transactions against a transaction-level model.
    task automatic test_random();
        logic rej;
        int act, val, p, idx, w;
        logic [N_DRINKS-1:0] mask;
        do_reset();
        for (int k = 0; k < 80; k++) begin
            act = $urandom_range(0, 5);
            if (act <= 3) begin
                bit c100 = (act == 2 || act == 3);
                bit c500 = (act <= 1 || act == 3);
                val = (c100 ? 1 : 0) + (c500 ? 5 : 0);
                coin(c100, c500, rej);
                if (m_credit + val > MAX_CREDIT) begin
                    n_checks++; if ({rej, credit} !== {1'b1, 8'(m_credit)}) begin n_fail++; $display("FAIL rand_coin_reject: rej=%0b c=%0d expected 1/%0d", rej, credit, m_credit); end
                end else begin
                    m_credit += val;
                    n_checks++; if ({rej, credit} !== {1'b0, 8'(m_credit)}) begin n_fail++; $display("FAIL rand_coin_add: rej=%0b c=%0d expected 0/%0d", rej, credit, m_credit); end
                end
            end else begin
                mask = N_DRINKS'($urandom_range(1, 15));
                idx  = $clog2(int'(mask & (~mask + 1'b1)));
                p    = price_tab[idx];
                drink_sel = mask;
                tick();
                drink_sel = '0;
                if (m_credit >= p) begin
                    m_credit -= p;
                    n_checks++; if ({enable, precioBebida, drink_id, credit} !== {1'b1, 8'(p), 2'(idx), 8'(m_credit)}) begin n_fail++; $display("FAIL rand_accept: en=%0b p=%0d id=%0d c=%0d expected 1/%0d/%0d/%0d", enable, precioBebida, drink_id, credit, p, idx, m_credit); end
                    w = $urandom_range(0, 3);
                    for (int j = 0; j < w; j++) tick();
                    readyIn = 1'b1;
                    tick();
                    readyIn = 1'b0;
                    if (m_credit > 0) begin
                        n_checks++; if ({enable, change_valid, vuelto, credit} !== {1'b0, 1'b1, 8'(m_credit), 8'd0}) begin n_fail++; $display("FAIL rand_change: en=%0b cv=%0b v=%0d c=%0d expected 0/1/%0d/0", enable, change_valid, vuelto, credit, m_credit); end
                        change_ack = 1'b1;
                        tick();
                        change_ack = 1'b0;
                        n_checks++; if ({change_valid, vuelto} !== '0) begin n_fail++; $display("FAIL rand_ack: cv=%0b v=%0d expected 0/0", change_valid, vuelto); end
                    end else begin
                        n_checks++; if ({enable, change_valid, precioBebida} !== '0) begin n_fail++; $display("FAIL rand_exact: en=%0b cv=%0b p=%0d expected 0/0/0", enable, change_valid, precioBebida); end
                    end
                    m_credit = 0;
                end else begin
                    n_checks++; if ({insufficient, enable, credit} !== {1'b1, 1'b0, 8'(m_credit)}) begin n_fail++; $display("FAIL rand_refuse: ins=%0b en=%0b c=%0d expected 1/0/%0d", insufficient, enable, credit, m_credit); end
                    tick();
                end
            end
        end
    endtask

    initial begin
        m_credit = 0;
        test_reset();
        test_basic_purchase();
        test_change_five();
        test_insufficient();
        test_saturation();
        test_priority_zero_change();
        test_back_to_back_ack();
        test_reset_mid_brew();
`ifdef COIN_CANCEL_EN
        test_cancel();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
